// File: rtl/prv_trap_ctrl_if.sv
// Trap sequencer bus: pipeline/hazard/CSR-side signals grouped into one bundle.
// The master side drives requests and pipeline status. The slave side is the
// trap controller, which answers with redirect and CSR update strobes.
interface prv_trap_ctrl_if #(
  parameter int NUM_EXC = 16,
  parameter int NUM_INT = 12,
  parameter int WORD_W  = 32
);
  logic [NUM_EXC-1:0] exc_req;
  logic [WORD_W-1:0]  exc_epc;
  logic [WORD_W-1:0]  exc_tval;
  logic [NUM_INT-1:0] int_pend;
  logic [NUM_INT-1:0] int_en;
  logic               global_ie;
  logic [WORD_W-1:0]  irq_epc;
  logic               xret;
  logic               wfi;
  logic               pipe_clear;
  logic [WORD_W-1:0]  xtvec;
  logic [WORD_W-1:0]  xepc_r;

  logic               insert_pc;
  logic [WORD_W-1:0]  priv_pc;
  logic               intr;
  logic               csr_upd;
  logic [WORD_W-1:0]  cause_out;
  logic [WORD_W-1:0]  epc_out;
  logic [WORD_W-1:0]  tval_out;
  logic               busy;
  logic               wfi_stall;

  modport master (
    output exc_req, exc_epc, exc_tval, int_pend, int_en, global_ie, irq_epc,
           xret, wfi, pipe_clear, xtvec, xepc_r,
    input  insert_pc, priv_pc, intr, csr_upd, cause_out, epc_out, tval_out,
           busy, wfi_stall
  );

  modport slave (
    input  exc_req, exc_epc, exc_tval, int_pend, int_en, global_ie, irq_epc,
           xret, wfi, pipe_clear, xtvec, xepc_r,
    output insert_pc, priv_pc, intr, csr_upd, cause_out, epc_out, tval_out,
           busy, wfi_stall
  );
endinterface

// File: rtl/prv_trap_ctrl.sv
// Trap sequencer. It priority-encodes exception and interrupt sources, latches
// cause/epc/tval, waits for the pipeline to drain, then issues one redirect
// strobe. The target is the trap vector (direct or vectored) or xepc for an
// xRET. WFI parks the controller in SLEEP until a line becomes pending.
module prv_trap_ctrl #(
  parameter int NUM_EXC = 16,
  parameter int NUM_INT = 12,
  parameter int WORD_W  = 32
) (
  input  logic           CLK,
  input  logic           RST,
  prv_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_REDIRECT = 2'd2,
    S_SLEEP    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_cause;
  logic [WORD_W-1:0] r_epc;
  logic [WORD_W-1:0] r_tval;
  logic              r_intr;
  logic              r_ret;

  logic [NUM_INT-1:0] w_int_vec;
  logic               w_any_int;
  logic               w_any_exc;
  logic               w_irq;
  logic               w_decide;
  logic               w_latch_exc;
  logic               w_latch_int;
  logic               w_latch_ret;
  logic [WORD_W-1:0]  w_exc_cause;
  logic [WORD_W-1:0]  w_int_cause;
  logic [WORD_W-1:0]  w_trap_base;
  logic [WORD_W-1:0]  w_vec_off;

  // Lowest-numbered exception wins.
  function automatic logic [WORD_W-1:0] f_lowest_exc(input logic [NUM_EXC-1:0] v);
    logic [WORD_W-1:0] code;
    code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (v[i]) code = WORD_W'(i);
    end
    return code;
  endfunction

  // Highest-numbered qualified interrupt wins.
  function automatic logic [WORD_W-1:0] f_highest_int(input logic [NUM_INT-1:0] v);
    logic [WORD_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      if (v[i]) code = WORD_W'(i);
    end
    return code;
  endfunction

  assign w_int_vec = bus.int_pend & bus.int_en;
  assign w_any_int = |w_int_vec;
  assign w_any_exc = |bus.exc_req;
  assign w_irq     = w_any_int & bus.global_ie;

  // Cause encodings for the two trap kinds; interrupts carry the MSB flag.
  always_comb begin
    w_exc_cause = f_lowest_exc(bus.exc_req);
    w_int_cause = f_highest_int(w_int_vec);
    w_int_cause[WORD_W-1] = 1'b1;
  end

  // Next-state logic: IDLE (and a qualified SLEEP wake) run the same
  // exception > interrupt > xret > wfi decision.
  always_comb begin
    w_state_nxt = r_state;
    w_decide    = 1'b0;
    w_latch_exc = 1'b0;
    w_latch_int = 1'b0;
    w_latch_ret = 1'b0;
    case (r_state)
      S_IDLE:     w_decide = 1'b1;
      S_DRAIN:    if (bus.pipe_clear) w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = S_IDLE;
      S_SLEEP: begin
        // Wake ignores global_ie; the trap is only taken if global_ie is set.
        if (w_any_int || w_any_exc) begin
          if (bus.global_ie) w_decide = 1'b1;
          else               w_state_nxt = S_IDLE;
        end
      end
      default:    w_state_nxt = S_IDLE;
    endcase
    if (w_decide) begin
      if (w_any_exc) begin
        w_latch_exc = 1'b1;
        w_state_nxt = S_DRAIN;
      end else if (w_irq) begin
        w_latch_int = 1'b1;
        w_state_nxt = S_DRAIN;
      end else if (bus.xret) begin
        w_latch_ret = 1'b1;
        w_state_nxt = S_DRAIN;
      end else if (bus.wfi) begin
        w_state_nxt = S_SLEEP;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // State register and trap latches; values freeze once DRAIN is entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cause <= '0;
      r_epc   <= '0;
      r_tval  <= '0;
      r_intr  <= 1'b0;
      r_ret   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_exc) begin
        r_cause <= w_exc_cause;
        r_epc   <= bus.exc_epc;
        r_tval  <= bus.exc_tval;
        r_intr  <= 1'b0;
        r_ret   <= 1'b0;
      end else if (w_latch_int) begin
        r_cause <= w_int_cause;
        r_epc   <= bus.irq_epc;
        r_tval  <= '0;
        r_intr  <= 1'b1;
        r_ret   <= 1'b0;
      end else if (w_latch_ret) begin
        r_intr  <= 1'b0;
        r_ret   <= 1'b1;
      end else if (r_state == S_REDIRECT) begin
        r_intr  <= 1'b0;
        r_ret   <= 1'b0;
      end
    end
  end

  assign w_trap_base = {bus.xtvec[WORD_W-1:2], 2'b00};
  assign w_vec_off   = (r_intr && (bus.xtvec[1:0] == 2'b01)) ?
                       {r_cause[WORD_W-3:0], 2'b00} : '0;

  // Output decode; the redirect target is only driven during REDIRECT.
  always_comb begin
    bus.insert_pc = (r_state == S_REDIRECT);
    bus.csr_upd   = (r_state == S_REDIRECT) && !r_ret;
    bus.priv_pc   = '0;
    if (r_state == S_REDIRECT) begin
      bus.priv_pc = r_ret ? bus.xepc_r : (w_trap_base + w_vec_off);
    end
    bus.intr      = r_intr;
    bus.cause_out = r_cause;
    bus.epc_out   = r_epc;
    bus.tval_out  = r_tval;
    bus.busy      = (r_state != S_IDLE);
    bus.wfi_stall = (r_state == S_SLEEP);
  end

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Bench for prv_trap_ctrl: directed vector table, then randomized cycles
// against a transaction-level reference model.
module tb_prv_trap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst;
  logic [15:0] t_exc;
  logic [11:0] t_ip;
  logic [11:0] t_en;
  logic        t_gie, t_xret, t_wfi, t_pclr;
  logic [31:0] t_xtvec, t_xepc, t_eepc, t_etval, t_iepc;

  prv_trap_ctrl_if #(.NUM_EXC(16), .NUM_INT(12), .WORD_W(32)) bus ();

  assign bus.exc_req    = t_exc;
  assign bus.exc_epc    = t_eepc;
  assign bus.exc_tval   = t_etval;
  assign bus.int_pend   = t_ip;
  assign bus.int_en     = t_en;
  assign bus.global_ie  = t_gie;
  assign bus.irq_epc    = t_iepc;
  assign bus.xret       = t_xret;
  assign bus.wfi        = t_wfi;
  assign bus.pipe_clear = t_pclr;
  assign bus.xtvec      = t_xtvec;
  assign bus.xepc_r     = t_xepc;

  prv_trap_ctrl #(.NUM_EXC(16), .NUM_INT(12), .WORD_W(32)) dut (
    .CLK (clk),
    .RST (t_rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rst;
    logic [15:0] exc;
    logic [11:0] ip;
    logic [11:0] en;
    logic        gie, xret, wfi, pclr;
    logic        e_ins;
    logic [31:0] e_pc;
    logic        e_csr, e_intr, e_busy, e_stall;
    logic [31:0] e_cause, e_epc, e_tval;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(
    input logic rst, input logic [15:0] exc, input logic [11:0] ip, input logic [11:0] en,
    input logic gie, input logic xret, input logic wfi, input logic pclr,
    input logic ins, input logic [31:0] pc, input logic csr, input logic intr,
    input logic busy, input logic stall,
    input logic [31:0] cause, input logic [31:0] epc, input logic [31:0] tval);
    vec_t v;
    v.rst = rst; v.exc = exc; v.ip = ip; v.en = en;
    v.gie = gie; v.xret = xret; v.wfi = wfi; v.pclr = pclr;
    v.e_ins = ins; v.e_pc = pc; v.e_csr = csr; v.e_intr = intr;
    v.e_busy = busy; v.e_stall = stall;
    v.e_cause = cause; v.e_epc = epc; v.e_tval = tval;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input logic ins, input logic [31:0] pc, input logic csr,
                         input logic intr, input logic busy, input logic stall,
                         input logic [31:0] cause, input logic [31:0] epc,
                         input logic [31:0] tval);
    n_vec++;
    chk("insert_pc", 32'(bus.insert_pc), 32'(ins));
    chk("priv_pc",   bus.priv_pc,        pc);
    chk("csr_upd",   32'(bus.csr_upd),   32'(csr));
    chk("intr",      32'(bus.intr),      32'(intr));
    chk("busy",      32'(bus.busy),      32'(busy));
    chk("wfi_stall", 32'(bus.wfi_stall), 32'(stall));
    chk("cause_out", bus.cause_out,      cause);
    chk("epc_out",   bus.epc_out,        epc);
    chk("tval_out",  bus.tval_out,       tval);
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_NONE, K_EXC, K_INT, K_RET} kind_e;
  kind_e       m_kind;
  bit          m_drain, m_redir, m_sleep;
  logic [31:0] m_cause, m_epc, m_tval;

  function automatic void model_reset();
    m_kind = K_NONE; m_drain = 0; m_redir = 0; m_sleep = 0;
    m_cause = 0; m_epc = 0; m_tval = 0;
  endfunction

  task automatic model_check();
    logic [31:0] pc;
    pc = 0;
    if (m_redir) begin
      if (m_kind == K_RET) pc = t_xepc;
      else begin
        pc = t_xtvec & ~32'h3;
        if (m_kind == K_INT && (t_xtvec & 32'h3) == 32'h1)
          pc = pc + 4 * (m_cause & 32'h7FFF_FFFF);
      end
    end
    chk_all(m_redir, pc, m_redir && m_kind != K_RET,
            m_kind == K_INT && (m_drain || m_redir),
            m_drain || m_redir || m_sleep, m_sleep, m_cause, m_epc, m_tval);
  endtask

  function automatic void model_update();
    bit wake;
    if (t_rst) begin
      model_reset();
    end else if (m_redir) begin
      m_redir = 0;
      m_kind  = K_NONE;
    end else if (m_drain) begin
      if (t_pclr) begin m_drain = 0; m_redir = 1; end
    end else begin
      wake = ((t_ip & t_en) != 0) || (t_exc != 0);
      if (m_sleep && !wake) begin
        m_sleep = 1;
      end else if (m_sleep && !t_gie) begin
        m_sleep = 0;
      end else begin
        m_sleep = 0;
        if (t_exc != 0) begin
          for (int i = 15; i >= 0; i--) if (t_exc[i]) m_cause = 32'(i);
          m_epc = t_eepc; m_tval = t_etval; m_kind = K_EXC; m_drain = 1;
        end else if (((t_ip & t_en) != 0) && t_gie) begin
          for (int i = 0; i < 12; i++) if (t_ip[i] && t_en[i]) m_cause = 32'h8000_0000 + 32'(i);
          m_epc = t_iepc; m_tval = 0; m_kind = K_INT; m_drain = 1;
        end else if (t_xret) begin
          m_kind = K_RET; m_drain = 1;
        end else if (t_wfi) begin
          m_sleep = 1;
        end
      end
    end
  endfunction

  initial begin
    t_rst = 1; t_exc = 0; t_ip = 0; t_en = 12'hFFF; t_gie = 0; t_xret = 0;
    t_wfi = 0; t_pclr = 0; t_xtvec = 32'h8000_0001; t_xepc = 32'h0000_0404;
    t_eepc = 32'h100; t_etval = 32'hBAD0; t_iepc = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    t_rst = 0;

    // rst  exc      ip       en       gie xrt wfi clr | ins pc            csr int bsy stl cause         epc    tval
    // exception, lowest index wins, pipe_clear after 3 drain cycles
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,   32'h0));
    tbl.push_back(V(0, 16'h0024, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,   32'h0));
    tbl.push_back(V(0, 16'h0024, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h2,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h2,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h2,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 0, 1, 32'h8000_0000, 1, 0, 1, 0, 32'h2,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h2,         32'h100, 32'hBAD0));
    // vectored interrupt, highest index (11) wins
    tbl.push_back(V(0, 16'h0000, 12'h880, 12'hFFF, 1, 0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h2,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h8000_000B, 32'h200, 32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 1, 32'h8000_002C, 1, 1, 1, 0, 32'h8000_000B, 32'h200, 32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h8000_000B, 32'h200, 32'h0));
    // exception beats simultaneous interrupt
    tbl.push_back(V(0, 16'h0008, 12'h080, 12'hFFF, 1, 0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h8000_000B, 32'h200, 32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 1, 32'h8000_0000, 1, 0, 1, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h3,         32'h100, 32'hBAD0));
    // xret, exception during drain ignored
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 1, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0001, 12'h000, 12'hFFF, 1, 0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0001, 12'h000, 12'hFFF, 1, 0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 1, 32'h0000_0404, 0, 0, 1, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h3,         32'h100, 32'hBAD0));
    // wfi with global_ie=0: five stall cycles, wake to IDLE, no trap
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h3,         32'h100, 32'hBAD0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,       0, 0, 1, 1, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h008, 12'h008, 0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 1, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h008, 12'h008, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h3,         32'h100, 32'hBAD0));
    // reset while draining
    tbl.push_back(V(0, 16'h0010, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h3,         32'h100, 32'hBAD0));
    tbl.push_back(V(1, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h4,         32'h100, 32'hBAD0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,   32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,   32'h0));
    // wfi with global_ie=1: wake takes the interrupt directly from SLEEP
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 1, 0, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0,   32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h004, 12'hFFF, 1, 0, 0, 1, 0, 32'h0,         0, 0, 1, 1, 32'h0,         32'h0,   32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h8000_0002, 32'h200, 32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 1, 32'h8000_0008, 1, 1, 1, 0, 32'h8000_0002, 32'h200, 32'h0));
    tbl.push_back(V(0, 16'h0000, 12'h000, 12'hFFF, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 32'h8000_0002, 32'h200, 32'h0));

    foreach (tbl[k]) begin
      t_rst = tbl[k].rst; t_exc = tbl[k].exc; t_ip = tbl[k].ip; t_en = tbl[k].en;
      t_gie = tbl[k].gie; t_xret = tbl[k].xret; t_wfi = tbl[k].wfi; t_pclr = tbl[k].pclr;
      @(negedge clk);
      chk_all(tbl[k].e_ins, tbl[k].e_pc, tbl[k].e_csr, tbl[k].e_intr, tbl[k].e_busy,
              tbl[k].e_stall, tbl[k].e_cause, tbl[k].e_epc, tbl[k].e_tval);
      @(posedge clk); #1;
    end

    // Randomized phase against the reference model.
    t_rst = 1; t_exc = 0; t_ip = 0; t_xret = 0; t_wfi = 0;
    @(posedge clk); #1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      t_rst   = ($urandom_range(0, 59) == 0);
      t_exc   = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h0;
      t_ip    = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h0;
      t_en    = 12'($urandom);
      t_gie   = 1'($urandom_range(0, 1));
      t_xret  = ($urandom_range(0, 7) == 0);
      t_wfi   = ($urandom_range(0, 5) == 0);
      t_pclr  = 1'($urandom_range(0, 1));
      t_xtvec = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
      t_xepc  = $urandom;
      t_eepc  = $urandom;
      t_etval = $urandom;
      t_iepc  = $urandom;
      @(negedge clk);
      model_check();
      model_update();
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prv_trap_ctrl.md
Name: prv_trap_ctrl

Overview:
Parametrised trap sequencer between the privilege block and the pipeline hazard unit. It generalises the fixed exception, interrupt and insert_pc signalling to N exception sources and M interrupt lines. It adds priority encoding, vectored or direct trap targets, xRET and WFI handling, and a drain handshake with the pipeline. It sits inside the priv block and drives insert_pc/priv_pc to hazard, plus the cause/epc/tval update strobe to the CSR file.

Parameters:
NUM_EXC, 16, exception source count; index = mcause exception code; lower index wins.
NUM_INT, 12, interrupt line count; index = mcause interrupt code; higher index wins (ext 11 > soft 3 > timer 7 ordering not used; pure index priority).
WORD_W, 32, address/data width.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
exc_req  in  NUM_EXC  exception requests from pipeline (level, valid while held)
exc_epc  in  WORD_W  PC of excepting instruction
exc_tval  in  WORD_W  bad address / instruction value
int_pend  in  NUM_INT  raw pending interrupt lines (mip)
int_en  in  NUM_INT  per-line enable (mie)
global_ie  in  1  mstatus.MIE
irq_epc  in  WORD_W  PC to resume after an interrupt
xret  in  1  mret/sret pulse from hazard
wfi  in  1  WFI pulse from hazard
pipe_clear  in  1  pipeline drained
xtvec  in  WORD_W  trap vector; bits[1:0]=mode (0 direct, 1 vectored)
xepc_r  in  WORD_W  current xepc for xRET
insert_pc  out  1  one-cycle redirect strobe
priv_pc  out  WORD_W  redirect target
intr  out  1  high while an interrupt trap is in flight
csr_upd  out  1  one-cycle strobe to write cause/epc/tval
cause_out  out  WORD_W  mcause value; MSB=interrupt flag
epc_out  out  WORD_W  latched epc
tval_out  out  WORD_W  latched tval (0 for interrupts)
busy  out  1  FSM not in IDLE
wfi_stall  out  1  holds pipeline while sleeping

Behaviour:
- Reset: state IDLE; all outputs 0; latches cleared. Reset in any state returns to IDLE next edge with no strobe emitted.
- States: IDLE, DRAIN, REDIRECT, SLEEP.
- Interrupt qualifier: irq = |(int_pend & int_en) & global_ie.
- IDLE:
  - Any exc_req -> latch lowest set index as cause (MSB 0), exc_epc, exc_tval; go DRAIN.
  - Else irq -> latch highest set qualified index (MSB 1), irq_epc, tval 0; set intr; go DRAIN.
  - Else xret -> mark return; go DRAIN.
  - Else wfi -> go SLEEP.
  - Priority: exception > interrupt > xret > wfi, evaluated in the same cycle.
- DRAIN: new requests are ignored; latched values are frozen. Stays until pipe_clear=1, then goes REDIRECT. If pipe_clear is already 1 on entry, REDIRECT follows next cycle. Minimum trap latency, request to insert_pc: 2 cycles.
- REDIRECT (exactly 1 cycle): insert_pc=1.
  - For a trap: csr_upd=1 and cause_out/epc_out/tval_out are valid.
  - priv_pc for a trap = {xtvec[WORD_W-1:2],2'b00}. For an interrupt in vectored mode, add 4*code; wraps modulo 2^WORD_W.
  - priv_pc for xret = xepc_r; csr_upd=0.
  - Next state IDLE; intr clears.
- SLEEP: wfi_stall=1. Exits when |(int_pend & int_en)=1, regardless of global_ie; a pending exc_req also exits.
  - If global_ie=1, exit goes straight to the IDLE decision logic in the same cycle (trap taken).
  - If global_ie=0, exit returns to IDLE and the pipeline resumes.
- busy = (state != IDLE).
- cause_out/epc_out/tval_out hold their last values until the next latch.

Test Plan:
- exc_req=16'h0024 (bits 2, 5), exc_epc=0x100, xtvec=0x8000_0001, pipe_clear after 3 cycles -> insert_pc at cycle 4, priv_pc=0x8000_0000, cause_out=2, epc_out=0x100, csr_upd 1 cycle.
- int_pend bits 7 and 11, int_en=all 1, global_ie=1, vectored xtvec=0x8000_0001, pipe_clear=1 -> insert_pc 2 cycles later, priv_pc=0x8000_002C, cause_out=0x8000_000B, tval_out=0, intr high until REDIRECT.
- Exception bit 3 and interrupt bit 7 in the same cycle -> cause_out=3, intr=0.
- xret with xepc_r=0x0000_0404 -> priv_pc=0x404, csr_upd=0; exc_req during DRAIN ignored.
- wfi with global_ie=0, then int_pend[3]=1 with int_en[3]=1 after 5 cycles -> wfi_stall high 5 cycles, returns IDLE, no insert_pc.
- RST asserted in DRAIN -> next cycle busy=0, insert_pc never pulses, outputs 0.
